// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode, state and width definitions for the ULA sequencer.
package ula_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 2;
  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLR = 4'd6;
  localparam logic [3:0] OP_SRR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_MAX = OP_ROL;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
endpackage

// File: rtl/ula_regfile.sv
// ula_regfile: register file with two operand read ports, a debug read port and one write port.
module ula_regfile import ula_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] a_addr,
  output logic [DATA_W-1:0] a_data,
  input  logic [REG_AW-1:0] b_addr,
  output logic [DATA_W-1:0] b_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] r [2**REG_AW];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '{default: '0};
    else if (we) r[waddr] <= wdata;

  assign a_data   = r[a_addr];
  assign b_data   = r[b_addr];
  assign dbg_data = r[dbg_addr];
endmodule

// File: rtl/ula_seq.sv
// ula_seq: multi-cycle sequencer driving an external combinational ULA over a small register file.
module ula_seq import ula_pkg::*; #(
  parameter int         DATA_W = DATA_W_DEF,
  parameter int         REG_AW = REG_AW_DEF,
  parameter logic [3:0] OP_LIM = OP_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  input  logic              cfg_we,
  input  logic [REG_AW-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] ula_A,
  output logic [DATA_W-1:0] ula_B,
  output logic [3:0]        ula_Seletor,
  input  logic [DATA_W-1:0] ula_S,
  input  logic              ula_ZERO,
  output logic              done,
  output logic              zero_flag,
  output logic              err
);
  state_t            state, nxt;
  logic [3:0]        op_q;
  logic [REG_AW-1:0] ra_q, rb_q, waddr;
  logic [DATA_W-1:0] s_q, rd_a, rd_b, wdata;
  logic              z_q, legal, accept, we;

  assign legal  = op_q <= OP_LIM;
  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  // cfg and writeback never collide: cfg is only honoured in IDLE
  always_comb begin
    nxt         = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    we          = 1'b0;
    waddr       = cfg_addr;
    wdata       = cfg_data;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        we          = cfg_we;
        nxt         = instr_valid ? READ : IDLE;
      end
      READ: nxt = EXEC;
      EXEC: nxt = WB;
      WB: begin
        done  = 1'b1;
        err   = !legal;
        we    = legal;
        waddr = ra_q;
        wdata = s_q;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      ula_A       <= '0;
      ula_B       <= '0;
      ula_Seletor <= '0;
      s_q         <= '0;
      z_q         <= 1'b0;
      zero_flag   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= instr_op;
        ra_q <= instr_ra;
        rb_q <= instr_rb;
      end
      if (state == READ) begin
        ula_A       <= rd_a;
        ula_B       <= rd_b;
        ula_Seletor <= op_q;
      end
      if (state == EXEC) begin
        s_q <= ula_S;
        z_q <= ula_ZERO;
      end
      if (state == WB && legal) zero_flag <= z_q;
    end

  ula_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .a_addr   (ra_q),
    .a_data   (rd_a),
    .b_addr   (rb_q),
    .b_data   (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq with a behavioural ULA attached.
module tb_ula_seq;
  logic       clk = 1'b0;
  logic       rst_n, instr_valid, instr_ready, cfg_we, ula_ZERO, done, zero_flag, err;
  logic [3:0] instr_op, ula_Seletor;
  logic [1:0] instr_ra, instr_rb, cfg_addr, dbg_addr;
  logic [7:0] cfg_data, dbg_data, ula_A, ula_B, ula_S;
  logic [15:0] rot;
  int n_chk = 0, n_err = 0;
  logic [3:0] bb_op [3] = '{4'd8, 4'd7, 4'd4};
  logic [7:0] bb_exp [3] = '{8'd16, 8'd4, 8'd6};

  always #5 clk = ~clk;

  ula_seq dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .ula_A(ula_A), .ula_B(ula_B), .ula_Seletor(ula_Seletor),
    .ula_S(ula_S), .ula_ZERO(ula_ZERO),
    .done(done), .zero_flag(zero_flag), .err(err)
  );

  // Behavioural ULA: shifts and rotate use the low 3 bits of B
  always_comb begin
    rot = {ula_A, ula_A} << ula_B[2:0];
    case (ula_Seletor)
      4'd0: ula_S = ~ula_A;
      4'd1: ula_S = ula_A & ula_B;
      4'd2: ula_S = ula_A | ula_B;
      4'd3: ula_S = ula_A ^ ula_B;
      4'd4: ula_S = ula_A + ula_B;
      4'd5: ula_S = ula_A - ula_B;
      4'd6: ula_S = ula_A << ula_B[2:0];
      4'd7: ula_S = ula_A >> ula_B[2:0];
      4'd8: ula_S = 8'(ula_A * ula_B);
      4'd9: ula_S = rot[15:8];
      default: ula_S = 8'd0;
    endcase
    ula_ZERO = ula_S == 8'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Issue one instruction from an IDLE negedge and follow it cycle by cycle to IDLE
  task automatic run(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                     input logic [7:0] ea, input logic [7:0] eb, input logic ee, input logic busy);
    instr_valid = 1'b1; instr_op = op; instr_ra = a; instr_rb = b;
    chk("accept_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    cfg_we = busy;
    chk("read_ready", instr_ready, 0);
    chk("read_done", done, 0);
    @(negedge clk);
    chk("exec_a", ula_A, ea);
    chk("exec_b", ula_B, eb);
    chk("exec_sel", ula_Seletor, op);
    chk("exec_done", done, 0);
    @(negedge clk);
    chk("wb_done", done, 1);
    chk("wb_err", err, ee);
    cfg_we = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_ready", instr_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_ra = '0; instr_rb = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_a", ula_A, 0);
    chk("rst_b", ula_B, 0);
    chk("rst_sel", ula_Seletor, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reg("rst_r0", 2'd0, 8'd0);

    cfg(2'd0, 8'd8);
    cfg(2'd1, 8'd2);
    chk_reg("pre_r0", 2'd0, 8'd8);
    run(4'd4, 2'd0, 2'd1, 8'd8, 8'd2, 1'b0, 1'b0);
    chk_reg("add_r0", 2'd0, 8'd10);
    chk("add_zero", zero_flag, 0);

    cfg(2'd2, 8'd5);
    run(4'd5, 2'd2, 2'd2, 8'd5, 8'd5, 1'b0, 1'b0);
    chk_reg("sub_r2", 2'd2, 8'd0);
    chk("sub_zero", zero_flag, 1);
    run(4'd2, 2'd2, 2'd1, 8'd0, 8'd2, 1'b0, 1'b0);
    chk_reg("or_r2", 2'd2, 8'd2);
    chk("or_zero", zero_flag, 0);

    cfg(2'd3, 8'd7);
    run(4'd12, 2'd3, 2'd1, 8'd7, 8'd2, 1'b1, 1'b0);
    chk_reg("ill_r3", 2'd3, 8'd7);
    chk("ill_zero", zero_flag, 0);

    cfg(2'd0, 8'd8);
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr_op = bb_op[k]; instr_ra = 2'd0; instr_rb = 2'd1;
      chk("bb_ready_idle", instr_ready, 1);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("bb_ready_busy", instr_ready, 0);
      end
      if (k == 2) instr_valid = 1'b0;
      @(negedge clk);
      chk_reg("bb_r0", 2'd0, bb_exp[k]);
    end

    cfg_addr = 2'd0; cfg_data = 8'h55;
    run(4'd4, 2'd1, 2'd1, 8'd2, 8'd2, 1'b0, 1'b1);
    chk_reg("busy_cfg_r0", 2'd0, 8'd6);
    chk_reg("busy_add_r1", 2'd1, 8'd4);

    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h33;
    run(4'd4, 2'd2, 2'd1, 8'h33, 8'd4, 1'b0, 1'b0);
    chk_reg("cfg_acc_r2", 2'd2, 8'h37);

    instr_valid = 1'b1; instr_op = 4'd4; instr_ra = 2'd0; instr_rb = 2'd1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_a", ula_A, 8'd6);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", instr_ready, 1);
    chk("arst_a", ula_A, 0);
    chk("arst_sel", ula_Seletor, 0);
    chk("arst_done", done, 0);
    chk_reg("arst_r1", 2'd1, 8'd0);
    chk_reg("arst_r2", 2'd2, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
    end
    chk_reg("post_rst_r0", 2'd0, 8'd0);
    cfg(2'd1, 8'd3);
    run(4'd4, 2'd1, 2'd1, 8'd3, 8'd3, 1'b0, 1'b0);
    chk_reg("post_rst_r1", 2'd1, 8'd6);
    chk("post_rst_zero", zero_flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Multi-cycle sequencer that owns the 8-bit ULA and a small register file R[0..3].
- Accepts one instruction (opcode, A-index, B-index) per valid/ready handshake and reads R[A] and R[B].
- Drives the ULA operands and Seletor, then writes the result back into R[A] and latches the ZERO flag.
- Sits between the Redux-V control path and the combinational ULA; the ULA is instantiated outside and connected through the ula_* ports.

Parameters:
- DATA_W, 8, width of registers and ULA operands.
- REG_AW, 2, register index width (2**REG_AW registers).
- OP_MAX, 9, highest legal ULA Seletor code; codes above it are illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  4  ULA Seletor code: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 SLR, 7 SRR, 8 MUL, 9 ROL.
- instr_ra  in  REG_AW  index of operand A and of the destination.
- instr_rb  in  REG_AW  index of operand B.
- cfg_we  in  1  register preload write strobe.
- cfg_addr  in  REG_AW  preload index.
- cfg_data  in  DATA_W  preload value.
- dbg_addr  in  REG_AW  debug read index.
- dbg_data  out  DATA_W  combinational R[dbg_addr].
- ula_A  out  DATA_W  operand A to the ULA.
- ula_B  out  DATA_W  operand B to the ULA.
- ula_Seletor  out  4  ULA operation select.
- ula_S  in  DATA_W  ULA result.
- ula_ZERO  in  1  ULA zero indication.
- done  out  1  one-cycle pulse when an instruction retires.
- zero_flag  out  1  sticky ZERO from the last legal retire.
- err  out  1  one-cycle pulse when an illegal opcode retires.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE and all registers R[i] clear to 0.
  - Outputs: instr_ready=1, ula_A=0, ula_B=0, ula_Seletor=0, done=0, zero_flag=0, err=0.
- Reset asserted mid-instruction aborts it: no writeback, no done pulse.
- States:
  - IDLE → READ on instr_valid && instr_ready. op, ra and rb are latched into internal registers.
  - READ: latch opA=R[ra] and opB=R[rb] → EXEC.
  - EXEC: ula_A, ula_B and ula_Seletor are registered outputs, valid throughout EXEC. At the end of EXEC, capture ula_S and ula_ZERO → WB.
  - WB:
    - Legal op: R[ra] ← captured S; zero_flag ← captured ZERO; done=1.
    - Illegal op (op > OP_MAX): no register write, zero_flag unchanged, done=1 and err=1.
    - Then → IDLE.
- instr_ready=1 only in IDLE.
- Latency: accept edge to done pulse = 3 cycles. Minimum issue interval is 4 cycles; a new accept may occur in the cycle after WB.
- ula_* outputs hold their last values outside EXEC. The ULA is combinational, so no wait states are needed.
- The sequencer does not modify results; the ULA defines truncation and width (e.g. MUL keeps the low DATA_W bits).
- ra == rb is legal; both operands read the same register.
- Register preload:
  - cfg_we is honoured only in IDLE and ignored in every other state.
  - If cfg_we and an accept occur in the same IDLE cycle, the cfg write takes effect first and READ sees the new value.
- dbg_data reflects a writeback on the cycle after WB.
- done and err are never asserted in IDLE except as the single retire pulse.

Decomposition:
- Shared package ula_pkg holds:
  - opcode localparams OP_NOT=0 … OP_ROL=9 and OP_MAX;
  - state encoding IDLE/READ/EXEC/WB (2-bit enum);
  - DATA_W and REG_AW defaults.
- One natural sub-module: ula_regfile. It has 2 combinational read ports plus 1 debug read port, and 1 write port muxed between cfg and writeback.
- The FSM and ULA interface stay in ula_seq.

Test Plan:
- Preload R0=8, R1=2; issue ADD (op 4, ra 0, rb 1) → ula_A=8 and ula_B=2 in EXEC; done 3 cycles after accept; R0=10; zero_flag=0.
- Preload R2=5; issue SUB (op 5, ra 2, rb 2) → R2=0, zero_flag=1. A following OR with result nonzero clears zero_flag.
- Issue op 12 with R3=7 → done and err pulse together; R3 stays 7; zero_flag unchanged.
- Back-to-back valid held high with 3 instructions → instr_ready=0 for 3 cycles between accepts; each op sees the previous result (8 MUL 2 = 16, then 16 SRR 2 = 4 via R1=2).
- cfg_we to R0 with 0x55 while in EXEC → ignored, R0 unchanged. cfg_we with 0x33 coincident with accept in IDLE → READ uses 0x33.
- Pull rst_n low in EXEC → asynchronous return to IDLE, all registers 0, no done pulse; first instruction after release completes normally.
